fakeram_sp_wmask: RTL and testbench
===================================

// Module: fakeram_sp_wmask
// PURPOSE
//  Parametrised single-port behavioural SRAM model (fakeram) for macro-level flows.
//  Adds per-lane write mask, selectable read latency, read-during-write mode,
//  defined out-of-range handling and optional post-reset zero-clear sequencer.
//  Drop-in behavioural stand-in for hardened SRAM macros in synthesis/sim builds.
// PARAMETERS
//  BITS            64  data word width
//  WORD_DEPTH      17  number of words; need not be a power of two
//  ADDR_WIDTH       5  address width; must be >= $clog2(WORD_DEPTH)
//  MASK_GRAN        8  bits per write-mask lane; BITS % MASK_GRAN == 0
//  RD_LAT           1  read latency in cycles, legal 1..4
//  RDW_MODE         0  0=read-first (old data), 1=write-first (merged new), 2=no-read
//  CLEAR_ON_RESET   1  1=zero all words after reset release; 0=contents untouched
// PORTS
//  clk           in   1                  rising-edge clock
//  rst_n_in      in   1                  async active-low reset
//  ce_in         in   1                  access enable; no access when 0
//  we_in         in   1                  write enable, qualified by ce_in
//  addr_in       in   ADDR_WIDTH         word address
//  wd_in         in   BITS               write data
//  wmask_in      in   BITS/MASK_GRAN     lane write enable, bit i -> wd_in lane i
//  rd_out        out  BITS               read data
//  rd_valid_out  out  1                  1-cycle pulse: rd_out carries read result
//  busy_out      out  1                  clear sequencer active; accesses ignored
// BEHAVIOUR
//  Reset (rst_n_in=0, async): rd_out=0, rd_valid_out=0, read pipeline flushed;
//   FSM -> CLEAR if CLEAR_ON_RESET else RUN; busy_out=CLEAR_ON_RESET. Memory not reset.
//  FSM CLEAR: busy_out=1; one word per cycle, row counter 0..WORD_DEPTH-1, writes 0.
//   After row WORD_DEPTH-1 written -> RUN next cycle, busy_out=0 (WORD_DEPTH cycles).
//   Reset asserted mid-CLEAR: counter restarts at 0 on release.
//   ce_in ignored in CLEAR: no write, no read, no rd_valid_out.
//  FSM RUN: access when ce_in=1 at rising edge.
//   Write (we_in=1): lanes with wmask_in[i]=1 take wd_in lane i; others keep old.
//   Read: every access with we_in=0 reads; with we_in=1 per RDW_MODE:
//    0 -> returns pre-write word; 1 -> returns merged post-write word;
//    2 -> no read, no rd_valid_out, rd_out holds.
//   Read of access at edge N: rd_out updated, rd_valid_out=1 during cycle after
//    edge N+RD_LAT-1 (RD_LAT=1: valid right after edge N). Fully pipelined,
//    one read per cycle, back-to-back sustained.
//   rd_out holds last read value when no read completes (never X from idle).
//  Out-of-range addr_in >= WORD_DEPTH: write dropped, read returns all-zero,
//   rd_valid_out still pulses.
//  Reset during pending reads: pending reads discarded, no late rd_valid_out.
//  Sim-only: assert on illegal params at elaboration; X on ce_in/we_in in RUN
//   reports error and corrupts addressed word to X.
// TESTING
//  T1 CLEAR_ON_RESET=1: release reset -> busy_out=1 for 17 cycles; then read all 17 -> 0.
//  T2 write addr 3 wd=0xFFFF..FF mask=all, then addr 3 wd=0, mask=8'h0F
//   -> read addr 3 = 0xFFFF_FFFF_0000_0000.
//  T3 RD_LAT=3: reads addr 0,1,2 back-to-back -> data in order, 3 cycles after each,
//   rd_valid_out high 3 consecutive cycles.
//  T4 addr 5 holds 0xA; write 0xB to addr 5 same cycle as read: RDW_MODE 0 -> 0xA,
//   1 -> 0xB, 2 -> no rd_valid_out and rd_out unchanged; mem[5]=0xB in all modes.
//  T5 write addr 20 (>=17) 0x5 -> no memory word changes; read addr 20 -> 0, valid=1.
//  T6 assert rst_n_in at CLEAR row 9 and with 2 reads in flight (RD_LAT=3)
//   -> no rd_valid_out; clear restarts at row 0, busy_out=1 for 17 cycles.

Source files
------------

// File: rtl/fakeram_sp_wmask.sv
// Behavioural single-port SRAM stand-in with per-lane write mask, 1..4 cycle
// pipelined read, selectable read-during-write behaviour and a post-reset clear.
module fakeram_sp_wmask #(
  parameter int BITS           = 64,
  parameter int WORD_DEPTH     = 17,
  parameter int ADDR_WIDTH     = 5,
  parameter int MASK_GRAN      = 8,
  parameter int RD_LAT         = 1,
  parameter int RDW_MODE       = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                          clk,
  input  logic                          rst_n_in,
  input  logic                          ce_in,
  input  logic                          we_in,
  input  logic [ADDR_WIDTH-1:0]         addr_in,
  input  logic [BITS-1:0]               wd_in,
  input  logic [BITS/MASK_GRAN-1:0]     wmask_in,
  output logic [BITS-1:0]               rd_out,
  output logic                          rd_valid_out,
  output logic                          busy_out
);

  localparam int LANES = BITS / MASK_GRAN;
  localparam int IDX_W = (WORD_DEPTH > 1) ? $clog2(WORD_DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(WORD_DEPTH - 1);

  if (BITS < 1 || MASK_GRAN < 1 || (BITS % MASK_GRAN) != 0 || WORD_DEPTH < 1 ||
      ADDR_WIDTH < IDX_W || ADDR_WIDTH > 32 || RD_LAT < 1 || RD_LAT > 4 ||
      RDW_MODE < 0 || RDW_MODE > 2 || (CLEAR_ON_RESET != 0 && CLEAR_ON_RESET != 1))
  begin : g_bad_params
    $fatal(1, "fakeram_sp_wmask: illegal parameter combination");
  end

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t           state_reg;
  logic [IDX_W-1:0] row_reg;
  logic             busy_reg;

  // Clear sequencer: walks every row once after reset release, then serves accesses.
  always_ff @(posedge clk or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_reg <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
      row_reg   <= '0;
      busy_reg  <= (CLEAR_ON_RESET != 0);
    end else begin
      case (state_reg)
        ST_CLEAR: begin
          if (row_reg == LAST_ROW) begin
            state_reg <= ST_RUN;
            busy_reg  <= 1'b0;
            row_reg   <= '0;
          end else begin
            row_reg <= row_reg + 1'b1;
          end
        end
        default: begin
          busy_reg <= 1'b0;
        end
      endcase
    end
  end

  assign busy_out = busy_reg;

  logic             run;
  logic             clr_fire;
  logic             in_range;
  logic             wr_fire;
  logic             rd_fire;
  logic             rdw_merge;
  logic             x_ctrl;
  logic [IDX_W-1:0] addr_idx;

  assign run       = rst_n_in && (state_reg == ST_RUN);
  assign clr_fire  = rst_n_in && (state_reg == ST_CLEAR);
  assign in_range  = 32'(addr_in) < 32'(WORD_DEPTH);
  assign addr_idx  = addr_in[IDX_W-1:0];
  assign wr_fire   = run && ce_in && we_in && in_range;
  // A write only suppresses its own read in no-read mode.
  assign rd_fire   = run && ce_in && (!we_in || (RDW_MODE != 2));
  assign rdw_merge = we_in && (RDW_MODE == 1);
  assign x_ctrl    = run && in_range && $isunknown({ce_in, we_in});

  logic [BITS-1:0] raw_word;

  // One narrow memory per mask lane keeps every write a plain full-width store.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [MASK_GRAN-1:0] lane_mem [WORD_DEPTH];
    logic [MASK_GRAN-1:0] lane_q;
    logic [MASK_GRAN-1:0] wd_lane;

    assign wd_lane = wd_in[gi*MASK_GRAN +: MASK_GRAN];

    always_ff @(posedge clk) begin
      if (clr_fire) begin
        lane_mem[row_reg] <= '0;
      end else if (x_ctrl) begin
        lane_mem[addr_idx] <= 'x;
      end else if (wr_fire && wmask_in[gi]) begin
        lane_mem[addr_idx] <= wd_lane;
      end
      if (rd_fire) begin
        if (!in_range) begin
          lane_q <= '0;
        end else if (rdw_merge && wmask_in[gi]) begin
          lane_q <= wd_lane;
        end else begin
          lane_q <= lane_mem[addr_idx];
        end
      end
    end

    assign raw_word[gi*MASK_GRAN +: MASK_GRAN] = lane_q;
  end

  logic [RD_LAT-1:0] vld_reg;

  always_ff @(posedge clk or negedge rst_n_in) begin
    if (!rst_n_in) begin
      vld_reg <= '0;
    end else begin
      vld_reg[0] <= rd_fire;
      for (int k = 1; k < RD_LAT; k++) begin
        vld_reg[k] <= vld_reg[k-1];
      end
    end
  end

  assign rd_valid_out = vld_reg[RD_LAT-1];

  logic [BITS-1:0] final_word;

  if (RD_LAT == 1) begin : g_lat1
    assign final_word = raw_word;
  end else begin : g_latn
    logic [BITS-1:0] dly_reg [RD_LAT-1];

    // Each stage only advances with a valid token, so the last stage holds between reads.
    always_ff @(posedge clk or negedge rst_n_in) begin
      if (!rst_n_in) begin
        for (int k = 0; k < RD_LAT - 1; k++) begin
          dly_reg[k] <= '0;
        end
      end else begin
        if (vld_reg[0]) begin
          dly_reg[0] <= raw_word;
        end
        for (int k = 1; k < RD_LAT - 1; k++) begin
          if (vld_reg[k]) begin
            dly_reg[k] <= dly_reg[k-1];
          end
        end
      end
    end

    assign final_word = dly_reg[RD_LAT-2];
  end

  logic out_seen_reg;

  always_ff @(posedge clk or negedge rst_n_in) begin
    if (!rst_n_in) begin
      out_seen_reg <= 1'b0;
    end else if (rd_valid_out) begin
      out_seen_reg <= 1'b1;
    end
  end

  // The read register itself is not reset, so blank the output until a read lands.
  assign rd_out = (out_seen_reg || rd_valid_out) ? final_word : '0;

  assert property (@(posedge clk) disable iff (!rst_n_in)
                   (state_reg == ST_RUN) |-> !$isunknown({ce_in, we_in}));

endmodule

// File: tb/tb_fakeram_sp_wmask.sv
// Randomised bench for fakeram_sp_wmask: three instances (different latency and
// read-during-write mode) share one stimulus and are checked against an array model.
module tb_fakeram_sp_wmask;

  localparam int NI    = 3;
  localparam int DEPTH = 17;
  localparam int AW    = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          ce = 1'b0;
  logic          we = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [63:0]   wd = '0;
  logic [7:0]    mask = '0;

  logic [63:0]   rd_w [NI];
  logic [NI-1:0] vld_w;
  logic [NI-1:0] busy_w;

  always #5 clk = ~clk;

  fakeram_sp_wmask #(.RD_LAT(1), .RDW_MODE(0)) u_dut0 (
    .clk(clk), .rst_n_in(rst_n), .ce_in(ce), .we_in(we), .addr_in(addr),
    .wd_in(wd), .wmask_in(mask), .rd_out(rd_w[0]), .rd_valid_out(vld_w[0]),
    .busy_out(busy_w[0]));

  fakeram_sp_wmask #(.RD_LAT(3), .RDW_MODE(1)) u_dut1 (
    .clk(clk), .rst_n_in(rst_n), .ce_in(ce), .we_in(we), .addr_in(addr),
    .wd_in(wd), .wmask_in(mask), .rd_out(rd_w[1]), .rd_valid_out(vld_w[1]),
    .busy_out(busy_w[1]));

  fakeram_sp_wmask #(.RD_LAT(2), .RDW_MODE(2)) u_dut2 (
    .clk(clk), .rst_n_in(rst_n), .ce_in(ce), .we_in(we), .addr_in(addr),
    .wd_in(wd), .wmask_in(mask), .rd_out(rd_w[2]), .rd_valid_out(vld_w[2]),
    .busy_out(busy_w[2]));

  int lat_m  [NI] = '{1, 3, 2};
  int mode_m [NI] = '{0, 1, 2};

  logic [63:0] mem_m  [NI][DEPTH];
  logic        ring_v [NI][8];
  logic [63:0] ring_d [NI][8];
  logic [63:0] last_m [NI];
  int          edge_cnt = 0;
  int          clr_left = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  bit          started = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int i, input logic [63:0] d);
    int slot;
    slot = (edge_cnt + lat_m[i] - 1) % 8;
    ring_v[i][slot] = 1'b1;
    ring_d[i][slot] = d;
  endtask

  task automatic model_reset();
    clr_left = DEPTH;
    for (int i = 0; i < NI; i++) begin
      last_m[i] = '0;
      for (int s = 0; s < 8; s++) ring_v[i][s] = 1'b0;
    end
  endtask

  // One clock edge of the reference: clear countdown, else the access rules.
  task automatic model_step();
    logic [63:0] old, merged;
    bit inr;
    int a;
    if (!rst_n) return;
    edge_cnt++;
    if (clr_left > 0) begin
      clr_left--;
      if (clr_left == 0)
        for (int i = 0; i < NI; i++)
          for (int w = 0; w < DEPTH; w++) mem_m[i][w] = '0;
    end else if (ce) begin
      a = int'(addr);
      inr = (a < DEPTH);
      for (int i = 0; i < NI; i++) begin
        old = inr ? mem_m[i][a] : 64'h0;
        merged = old;
        for (int l = 0; l < 8; l++)
          if (mask[l]) merged[l*8 +: 8] = wd[l*8 +: 8];
        if (we && inr) mem_m[i][a] = merged;
        if (!we || mode_m[i] == 0) push(i, old);
        else if (mode_m[i] == 1) push(i, inr ? merged : 64'h0);
      end
    end
  endtask

  task automatic compare_cycle();
    int slot;
    logic ev;
    slot = edge_cnt % 8;
    for (int i = 0; i < NI; i++) begin
      ev = ring_v[i][slot];
      if (ev) last_m[i] = ring_d[i][slot];
      ring_v[i][slot] = 1'b0;
      chk($sformatf("valid[%0d]", i), {63'h0, vld_w[i]}, {63'h0, ev});
      chk($sformatf("rd_out[%0d]", i), rd_w[i], last_m[i]);
      chk($sformatf("busy[%0d]", i), {63'h0, busy_w[i]}, {63'h0, clr_left != 0});
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (started) compare_cycle();
    end
  end

  task automatic tick(input logic c, input logic w, input logic [AW-1:0] a,
                      input logic [63:0] d, input logic [7:0] m);
    ce = c; we = w; addr = a; wd = d; mask = m;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    tick(1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic measure_busy(input string name);
    int n;
    n = 0;
    while (busy_w[0] && n < 40) begin
      idle();
      n++;
    end
    chk(name, 64'(n), 64'd17);
  endtask

  initial begin
    #2;
    rst_n = 1'b0;
    model_reset();
    started = 1'b1;
    #1;
    chk("reset_rd_out", rd_w[0], 64'h0);
    chk("reset_busy", {63'h0, busy_w[0]}, 64'h1);
    idle();
    idle();
    rst_n = 1'b1;

    // Clear phase length, then every word reads zero.
    measure_busy("clear_len");
    for (int a = 0; a < DEPTH; a++) begin
      tick(1'b1, 1'b0, AW'(a), {$urandom, $urandom}, 8'h00);
      chk("cleared_valid", {63'h0, vld_w[0]}, 64'h1);
      chk("cleared_word", rd_w[0], 64'h0);
    end

    // Lane mask merge.
    tick(1'b1, 1'b1, 5'd3, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    tick(1'b1, 1'b1, 5'd3, 64'h0, 8'h0F);
    tick(1'b1, 1'b0, 5'd3, 64'h0, 8'h00);
    chk("mask_merge", rd_w[0], 64'hFFFF_FFFF_0000_0000);

    // Back-to-back reads through the three-cycle instance.
    tick(1'b1, 1'b1, 5'd0, 64'h1111, 8'hFF);
    tick(1'b1, 1'b1, 5'd1, 64'h2222, 8'hFF);
    tick(1'b1, 1'b1, 5'd2, 64'h3333, 8'hFF);
    repeat (3) idle();
    tick(1'b1, 1'b0, 5'd0, 64'h0, 8'h00);
    chk("lat3_early0", {63'h0, vld_w[1]}, 64'h0);
    tick(1'b1, 1'b0, 5'd1, 64'h0, 8'h00);
    chk("lat3_early1", {63'h0, vld_w[1]}, 64'h0);
    tick(1'b1, 1'b0, 5'd2, 64'h0, 8'h00);
    chk("lat3_v0", {63'h0, vld_w[1]}, 64'h1);
    chk("lat3_d0", rd_w[1], 64'h1111);
    idle();
    chk("lat3_v1", {63'h0, vld_w[1]}, 64'h1);
    chk("lat3_d1", rd_w[1], 64'h2222);
    idle();
    chk("lat3_v2", {63'h0, vld_w[1]}, 64'h1);
    chk("lat3_d2", rd_w[1], 64'h3333);
    idle();
    chk("lat3_end", {63'h0, vld_w[1]}, 64'h0);

    // Read during write in each mode.
    tick(1'b1, 1'b1, 5'd5, 64'hA, 8'hFF);
    repeat (3) idle();
    tick(1'b1, 1'b1, 5'd5, 64'hB, 8'hFF);
    chk("rdw_first_v", {63'h0, vld_w[0]}, 64'h1);
    chk("rdw_first_d", rd_w[0], 64'hA);
    idle();
    chk("rdw_none_v", {63'h0, vld_w[2]}, 64'h0);
    chk("rdw_none_hold", rd_w[2], 64'h3333);
    idle();
    chk("rdw_merge_v", {63'h0, vld_w[1]}, 64'h1);
    chk("rdw_merge_d", rd_w[1], 64'hB);
    tick(1'b1, 1'b0, 5'd5, 64'h0, 8'h00);
    chk("rdw_stored", rd_w[0], 64'hB);

    // Out-of-range write is dropped, read returns zero with a valid pulse.
    tick(1'b1, 1'b1, 5'd20, 64'h5, 8'hFF);
    tick(1'b1, 1'b0, 5'd20, 64'h0, 8'h00);
    chk("oor_valid", {63'h0, vld_w[0]}, 64'h1);
    chk("oor_data", rd_w[0], 64'h0);
    for (int a = 0; a < DEPTH; a++) tick(1'b1, 1'b0, AW'(a), 64'h0, 8'h00);

    repeat (600) begin
      tick(($urandom_range(3) != 0), $urandom_range(1) == 1, AW'($urandom_range(22)),
           {$urandom, $urandom}, 8'($urandom));
    end
    repeat (4) idle();

    // Reset with reads in flight, then reset in the middle of the clear walk.
    tick(1'b1, 1'b0, 5'd1, 64'h0, 8'h00);
    tick(1'b1, 1'b0, 5'd2, 64'h0, 8'h00);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("flush_valid", {63'h0, vld_w[1]}, 64'h0);
    repeat (3) begin
      idle();
      chk("flush_late", {63'h0, vld_w[1]}, 64'h0);
    end
    rst_n = 1'b1;
    repeat (9) idle();
    rst_n = 1'b0;
    model_reset();
    idle();
    idle();
    rst_n = 1'b1;
    measure_busy("restart_len");
    for (int a = 0; a < DEPTH; a++) tick(1'b1, 1'b0, AW'(a), 64'h0, 8'h00);
    repeat (4) idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
